fifo_drain_serializer: RTL and testbench
========================================

# fifo_drain_serializer

Downstream drain stage for the synchronous FIFO. It pops words from the FIFO read port, accounting for the FIFO's one-cycle registered read latency. It buffers popped words in a 3-entry prefetch queue and emits each word as IN_WIDTH/OUT_WIDTH narrower beats, LSB first, on a valid/ready stream. It never reads an empty FIFO, so the FIFO's underflow flag stays low, and it counts fully drained words for status.

## Interface
- IN_WIDTH, default 16: FIFO word width. Must equal FIFO data width.
- OUT_WIDTH, default 8: output beat width. IN_WIDTH % OUT_WIDTH must be 0; otherwise elaboration fails via $error.
- CNT_WIDTH, default 16: width of the drained-word counter.
- Derived: RATIO = IN_WIDTH/OUT_WIDTH (beats per word, ≥1); BEAT_W = max(1, $clog2(RATIO)).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  permits new FIFO reads; buffered words still drain when low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  IN_WIDTH  FIFO data_out, valid the cycle after an accepted read.
- fifo_rd_en  out  1  FIFO read request.
- out_data  out  OUT_WIDTH  current beat.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts beat.
- out_last  out  1  current beat is the final beat of its word.
- words_drained  out  CNT_WIDTH  count of words whose last beat was accepted; wraps modulo 2^CNT_WIDTH.

## Operation
- State:
  - 3-entry circular word queue: wr_idx, rd_idx, occ 0..3.
  - inflight flag: fifo_rd_en registered.
  - beat index beat 0..RATIO-1.
  - words_drained counter.
- Read issue is combinational from registers only:
  - fifo_rd_en = en && !fifo_empty && (occ + inflight < 3).
  - No path from out_ready to fifo_rd_en.
- Capture: when inflight=1, fifo_data is written to queue[wr_idx] at that edge, and wr_idx advances mod 3.
- Output:
  - out_valid = (occ != 0).
  - out_data = queue[rd_idx][beat*OUT_WIDTH +: OUT_WIDTH].
  - out_last = out_valid && (beat == RATIO-1).
- Beat handshake (out_valid && out_ready):
  - If not last: beat increments.
  - If last: beat goes to 0, rd_idx advances mod 3, and words_drained increments.
- occ update:
  - +1 on capture, −1 on last-beat handshake.
  - Both in the same cycle: unchanged.
  - occ never exceeds 3 by construction; an assertion must fire if it would.
- Stream rules: while out_valid=1 and out_ready=0, out_data and out_last are held stable. out_valid never drops without a handshake.
- en deassertion:
  - Stops new fifo_rd_en immediately.
  - An in-flight read still captures.
  - Queued words continue to drain.
- RATIO=1: beat is held at 0 and every handshake is a last beat.

## Timing
- Reset values: fifo_rd_en=0, out_valid=0, out_last=0, out_data=0, words_drained=0; occ=0, inflight=0, beat=0, all indices 0.
- Reset mid-operation clears all state asynchronously, including the in-flight read and any partially sent word. rst_n is shared with the FIFO, so no data is owed.
- Latency:
  - fifo_rd_en high in cycle N → word captured at end of N+1 → out_valid high in cycle N+2.
  - First beat of an idle-to-active transfer: 2 cycles after fifo_rd_en.
- Throughput: with out_ready held high and the FIFO non-empty, the block sustains one word per RATIO cycles. For RATIO=1 that is fifo_rd_en high every cycle in steady state.
- Boundaries:
  - fifo_empty=1: fifo_rd_en=0 in the same cycle.
  - Queue full (occ + inflight == 3): fifo_rd_en=0.
  - Index wrap 2→0 on both pointers.
  - Simultaneous capture and last-beat pop keeps occ constant.

## Test plan
- Single word: FIFO holds 16'hA55A, RATIO=2, out_ready=1 → fifo_rd_en for 1 cycle. Beats 8'h5A (out_last=0) then 8'hA5 (out_last=1), first beat 2 cycles after rd_en. words_drained=1. FIFO underflow stays 0.
- Back-pressure: 4 words queued, out_ready=0 for 20 cycles → fifo_rd_en pulses exactly 3 times, then stays 0. out_data/out_valid are stable throughout. On release, 8 beats arrive in order and words_drained=4.
- Streaming: RATIO=1, 10 words in the FIFO, out_ready=1 → after the 2-cycle fill, 10 consecutive beats with no bubble. fifo_rd_en drops the cycle fifo_empty rises.
- en gating: deassert en one cycle after a read issues → that word still captures and drains. No further fifo_rd_en while en=0, even with fifo_empty=0.
- Reset mid-word: assert rst_n=0 after beat 0 of a 2-beat word → out_valid=0, words_drained=0, beat=0 immediately. After release, the next word starts at beat 0.
- Counter wrap: CNT_WIDTH=4, drain 17 words → words_drained reads 1.

Source files
------------

// File: rtl/fifo_drain_serializer_if.sv
// Port bundle between the FIFO read side, the drain serializer and the beat sink.
// Stream handshake: a beat transfers on a rising edge where out_valid && out_ready;
// once out_valid is high it stays high, with out_data/out_last unchanged, until that transfer.
interface fifo_drain_serializer_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 en;
    logic                 fifo_empty;
    logic [IN_WIDTH-1:0]  fifo_data;
    logic                 fifo_rd_en;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [CNT_WIDTH-1:0] words_drained;

    modport master (
        input  en, fifo_empty, fifo_data, out_ready,
        output fifo_rd_en, out_data, out_valid, out_last, words_drained
    );

    modport slave (
        output en, fifo_empty, fifo_data, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_last, words_drained
    );
endinterface

// File: rtl/fifo_drain_serializer.sv
// Pops words from a registered-read FIFO into a 3-entry prefetch queue and
// emits each word as IN_WIDTH/OUT_WIDTH beats, LSB first, on a valid/ready stream.
module fifo_drain_serializer #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fifo_drain_serializer_if.master   bus
);
    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int DEPTH  = 3;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || IN_WIDTH < OUT_WIDTH) begin : g_bad_ratio
            $error("fifo_drain_serializer: IN_WIDTH must be a multiple of OUT_WIDTH");
        end
    endgenerate

    logic [IN_WIDTH-1:0]  r_queue [DEPTH];
    logic [1:0]           r_wr_idx;
    logic [1:0]           r_rd_idx;
    logic [1:0]           r_occ;
    logic                 r_inflight;
    logic [BEAT_W-1:0]    r_beat;
    logic [CNT_WIDTH-1:0] r_drained;

    logic [2:0]           w_slots_used;
    logic                 w_rd_en;
    logic                 w_valid;
    logic                 w_last_beat;
    logic                 w_hs;
    logic                 w_pop;
    logic [IN_WIDTH-1:0]  w_head;
    logic [OUT_WIDTH-1:0] w_beat_data;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // A read in flight already owns a slot, so it counts against the queue depth.
    assign w_slots_used = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_rd_en      = bus.en && !bus.fifo_empty && (w_slots_used < 3'd3);

    assign w_valid      = (r_occ != 2'd0);
    assign w_last_beat  = (r_beat == LAST_BEAT);
    assign w_hs         = w_valid && bus.out_ready;
    assign w_pop        = w_hs && w_last_beat;

    assign w_head       = r_queue[r_rd_idx];
    assign w_beat_data  = w_head[int'(r_beat)*OUT_WIDTH +: OUT_WIDTH];

    assign bus.fifo_rd_en    = w_rd_en;
    assign bus.out_valid     = w_valid;
    assign bus.out_last      = w_valid && w_last_beat;
    assign bus.out_data      = w_valid ? w_beat_data : '0;
    assign bus.words_drained = r_drained;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_queue[i] <= '0;
            end
            r_wr_idx   <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            // fifo_data belongs to the read issued on the previous edge.
            if (r_inflight) begin
                r_queue[r_wr_idx] <= bus.fifo_data;
                r_wr_idx          <= next_idx(r_wr_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_idx  <= 2'd0;
            r_beat    <= '0;
            r_drained <= '0;
        end else if (w_hs) begin
            if (w_last_beat) begin
                r_beat    <= '0;
                r_rd_idx  <= next_idx(r_rd_idx);
                r_drained <= r_drained + 1'b1;
            end else begin
                r_beat    <= r_beat + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= 2'd0;
        end else begin
            case ({r_inflight, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    a_occ_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(r_inflight && !w_pop && (r_occ == 2'd3))
    ) else $error("fifo_drain_serializer: prefetch queue overflow");

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: a RATIO=2 instance with a 4-bit counter and a
// RATIO=1 instance, each fed by a registered-read FIFO model and a beat scoreboard.
module tb_fifo_drain_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- instance A: 16 -> 8, 4-bit counter ----------------
    fifo_drain_serializer_if #(.IN_WIDTH(16), .OUT_WIDTH(8), .CNT_WIDTH(4)) a_if ();
    fifo_drain_serializer #(.IN_WIDTH(16), .OUT_WIDTH(8), .CNT_WIDTH(4)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    logic [15:0] a_fifo_q[$];
    logic [8:0]  exp_q_a[$];
    int a_pushed = 0;
    int a_popped = 0;
    int a_rd_cnt = 0, a_uflow = 0, a_stall_bad = 0;
    int a_first_rd = -1, a_first_vld = -1;
    logic       a_prev_stall = 1'b0;
    logic [8:0] a_prev_beat = '0;

    assign a_if.fifo_empty = (a_pushed == a_popped);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_if.fifo_data <= '0;
            a_popped       <= 0;
        end else if (a_if.fifo_rd_en && a_fifo_q.size() != 0) begin
            a_if.fifo_data <= a_fifo_q.pop_front();
            a_popped       <= a_popped + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            a_prev_stall = 1'b0;
        end else begin
            if (a_if.fifo_rd_en) begin
                a_rd_cnt++;
                if (a_if.fifo_empty) a_uflow++;
                if (a_first_rd < 0) a_first_rd = cyc;
            end
            if (a_if.out_valid && a_first_vld < 0) a_first_vld = cyc;
            if (a_prev_stall && !(a_if.out_valid && {a_if.out_last, a_if.out_data} == a_prev_beat))
                a_stall_bad++;
            a_prev_stall = a_if.out_valid && !a_if.out_ready;
            a_prev_beat  = {a_if.out_last, a_if.out_data};
            if (a_if.out_valid && a_if.out_ready) begin
                if (exp_q_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_extra_beat actual=0x%0h expected=none", {a_if.out_last, a_if.out_data});
                end else begin
                    check("a_beat", 32'({a_if.out_last, a_if.out_data}), 32'(exp_q_a.pop_front()));
                end
            end
        end
    end

    task automatic a_push(input logic [15:0] w);
        a_fifo_q.push_back(w);
        a_pushed++;
    endtask

    task automatic a_expect(input logic [7:0] d, input logic l);
        exp_q_a.push_back({l, d});
    endtask

    task automatic a_push_split(input logic [15:0] w);
        a_push(w);
        a_expect(w[7:0], 1'b0);
        a_expect(w[15:8], 1'b1);
    endtask

    task automatic a_wait_drained(input logic [3:0] n, input string name);
        int k = 0;
        while (a_if.words_drained != n && k < 300) begin
            tick(1);
            k++;
        end
        check(name, 32'(a_if.words_drained), 32'(n));
    endtask

    task automatic a_wait_sb_empty(input string name);
        int k = 0;
        while (exp_q_a.size() != 0 && k < 300) begin
            tick(1);
            k++;
        end
        check(name, 32'(exp_q_a.size()), 32'd0);
    endtask

    // ---------------- instance B: 8 -> 8 (one beat per word) ----------------
    fifo_drain_serializer_if #(.IN_WIDTH(8), .OUT_WIDTH(8), .CNT_WIDTH(16)) b_if ();
    fifo_drain_serializer #(.IN_WIDTH(8), .OUT_WIDTH(8), .CNT_WIDTH(16)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    logic [7:0] b_fifo_q[$];
    logic [8:0] exp_q_b[$];
    int b_pushed = 0;
    int b_popped = 0;
    int b_rd_cnt = 0, b_uflow = 0, b_rd_run = 0, b_rd_max = 0, b_vld_run = 0, b_vld_max = 0;

    assign b_if.fifo_empty = (b_pushed == b_popped);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_if.fifo_data <= '0;
            b_popped       <= 0;
        end else if (b_if.fifo_rd_en && b_fifo_q.size() != 0) begin
            b_if.fifo_data <= b_fifo_q.pop_front();
            b_popped       <= b_popped + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_if.fifo_rd_en) begin
                b_rd_cnt++;
                b_rd_run++;
                if (b_rd_run > b_rd_max) b_rd_max = b_rd_run;
                if (b_if.fifo_empty) b_uflow++;
            end else begin
                b_rd_run = 0;
            end
            if (b_if.out_valid) begin
                b_vld_run++;
                if (b_vld_run > b_vld_max) b_vld_max = b_vld_run;
            end else begin
                b_vld_run = 0;
            end
            if (b_if.out_valid && b_if.out_ready) begin
                if (exp_q_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_extra_beat actual=0x%0h expected=none", {b_if.out_last, b_if.out_data});
                end else begin
                    check("b_beat", 32'({b_if.out_last, b_if.out_data}), 32'(exp_q_b.pop_front()));
                end
            end
        end
    end

    task automatic b_push(input logic [7:0] w);
        b_fifo_q.push_back(w);
        b_pushed++;
        exp_q_b.push_back({1'b1, w});
    endtask

    // ---------------- shared reset driver ----------------
    task automatic flush_a();
        a_fifo_q.delete();
        exp_q_a.delete();
        a_pushed = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush_a();
        b_fifo_q.delete();
        exp_q_b.delete();
        b_pushed = 0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        a_if.en = 1'b1;
        a_if.out_ready = 1'b0;
        b_if.en = 1'b0;
        b_if.out_ready = 1'b0;
        do_reset();

        // reset state
        check("rst_rd_en",   32'(a_if.fifo_rd_en),    32'd0);
        check("rst_valid",   32'(a_if.out_valid),     32'd0);
        check("rst_last",    32'(a_if.out_last),      32'd0);
        check("rst_data",    32'(a_if.out_data),      32'd0);
        check("rst_drained", 32'(a_if.words_drained), 32'd0);

        // single word, beats 5A then A5
        a_if.out_ready = 1'b1;
        a_rd_cnt = 0;
        a_first_rd = -1;
        a_first_vld = -1;
        a_push(16'hA55A);
        a_expect(8'h5A, 1'b0);
        a_expect(8'hA5, 1'b1);
        a_wait_drained(4'd1, "t1_drained");
        tick(3);
        check("t1_rd_pulses", 32'(a_rd_cnt), 32'd1);
        check("t1_latency", 32'(a_first_vld - a_first_rd), 32'd2);
        check("t1_sb_empty", 32'(exp_q_a.size()), 32'd0);

        // back-pressure: only three reads while the sink stalls
        a_if.out_ready = 1'b0;
        a_rd_cnt = 0;
        a_stall_bad = 0;
        a_push_split(16'h0102);
        a_push_split(16'h0304);
        a_push_split(16'h0506);
        a_push_split(16'h0708);
        tick(20);
        check("t2_rd_pulses_stalled", 32'(a_rd_cnt), 32'd3);
        check("t2_hold_valid", 32'(a_if.out_valid), 32'd1);
        check("t2_hold_data", 32'(a_if.out_data), 32'h02);
        check("t2_hold_last", 32'(a_if.out_last), 32'd0);
        a_if.out_ready = 1'b1;
        a_wait_drained(4'd5, "t2_drained");
        tick(3);
        check("t2_rd_pulses_total", 32'(a_rd_cnt), 32'd4);
        check("t2_stall_stable", 32'(a_stall_bad), 32'd0);
        check("t2_sb_empty", 32'(exp_q_a.size()), 32'd0);

        // en gating: one read issued, then en low
        a_if.en = 1'b0;
        a_push_split(16'hC0DE);
        a_push_split(16'hFACE);
        a_push_split(16'h7E57);
        tick(2);
        a_rd_cnt = 0;
        a_if.en = 1'b1;
        tick(1);
        a_if.en = 1'b0;
        tick(15);
        check("t3_rd_pulses", 32'(a_rd_cnt), 32'd1);
        check("t3_drained_one", 32'(a_if.words_drained), 32'd6);
        check("t3_fifo_nonempty", 32'(a_if.fifo_empty), 32'd0);
        a_if.en = 1'b1;
        a_wait_drained(4'd8, "t3_drained_all");
        tick(3);
        check("t3_sb_empty", 32'(exp_q_a.size()), 32'd0);

        // reset in the middle of a word
        a_push_split(16'h1234);
        begin
            int k = 0;
            while (exp_q_a.size() != 1 && k < 50) begin
                tick(1);
                k++;
            end
        end
        check("t4_mid_last", 32'(a_if.out_last), 32'd1);
        check("t4_mid_data", 32'(a_if.out_data), 32'h12);
        rst_n = 1'b0;
        flush_a();
        #1;
        check("t4_rst_valid", 32'(a_if.out_valid), 32'd0);
        check("t4_rst_last", 32'(a_if.out_last), 32'd0);
        check("t4_rst_drained", 32'(a_if.words_drained), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        a_push_split(16'hBEEF);
        a_wait_drained(4'd1, "t4_after_rst_drained");
        tick(2);
        check("t4_sb_empty", 32'(exp_q_a.size()), 32'd0);

        // counter wrap: 17 words on a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            a_push_split(16'h1000 + 16'(i) * 16'h0101);
        end
        a_wait_sb_empty("t5_sb_empty");
        tick(3);
        check("t5_wrap", 32'(a_if.words_drained), 32'd1);
        check("a_underflow", 32'(a_uflow), 32'd0);

        // one-beat words streaming back to back
        b_if.en = 1'b1;
        b_if.out_ready = 1'b1;
        b_rd_cnt = 0;
        b_rd_max = 0;
        b_vld_max = 0;
        for (int i = 0; i < 10; i++) begin
            b_push(8'h11 * 8'(i + 1));
        end
        tick(30);
        check("t6_rd_pulses", 32'(b_rd_cnt), 32'd10);
        check("t6_rd_run", 32'(b_rd_max), 32'd10);
        check("t6_no_bubble", 32'(b_vld_max), 32'd10);
        check("t6_drained", 32'(b_if.words_drained), 32'd10);
        check("t6_underflow", 32'(b_uflow), 32'd0);
        check("t6_rd_idle", 32'(b_if.fifo_rd_en), 32'd0);
        check("t6_sb_empty", 32'(exp_q_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
